rom_writer: RTL

ROM_WRITER -- requirements
Module: rom_writer

---
 rtl/rom_writer.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/rom_writer.sv
// Programmer for bipolar fuse PROMs (IP3604 / IP3601): verify the addressed word,
// then blow missing fuses one at a time, re-verifying after every pulse.
module rom_writer #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDRESS_WIDTH  = 9,
  parameter int SETTLE_CYCLES  = 4,
  parameter int SETUP_CYCLES   = 4,
  parameter int PULSE_CYCLES   = 16,
  parameter int RECOVER_CYCLES = 8,
  parameter int MAX_PULSES     = 32
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic [ADDRESS_WIDTH-1:0] write_address,
  input  logic [DATA_WIDTH-1:0]    write_data,
  input  logic [DATA_WIDTH-1:0]    data_line_in,
  output logic [ADDRESS_WIDTH-1:0] address_line,
  output logic [3:0]               operation,
  output logic [DATA_WIDTH-1:0]    program_strobe,
  output logic                     vpp_enable,
  output logic                     busy,
  output logic                     done,
  output logic [1:0]               error_code,
  output logic [DATA_WIDTH-1:0]    read_data
);

  localparam int MAX_A = (SETTLE_CYCLES > SETUP_CYCLES) ? SETTLE_CYCLES : SETUP_CYCLES;
  localparam int MAX_B = (PULSE_CYCLES > RECOVER_CYCLES) ? PULSE_CYCLES : RECOVER_CYCLES;
  localparam int MAX_CYCLES = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int COUNT_WIDTH = $clog2(MAX_CYCLES + 1);
  localparam int PULSE_COUNT_WIDTH = $clog2(MAX_PULSES + 1);
  localparam int INDEX_WIDTH = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [2:0] {
    IDLE, VERIFY, SETUP, PULSE, RECOVER, DONE
  } state_t;

  state_t                       state;
  state_t                       state_next;
  logic [COUNT_WIDTH-1:0]       cycle_count;
  logic [PULSE_COUNT_WIDTH-1:0] pulse_count;
  logic [ADDRESS_WIDTH-1:0]     address_reg;
  logic [DATA_WIDTH-1:0]        target_reg;
  logic [INDEX_WIDTH-1:0]       bit_select;
  logic [INDEX_WIDTH-1:0]       lowest_index;
  logic [DATA_WIDTH-1:0]        missing;
  logic                         settle_last;
  logic                         setup_last;
  logic                         pulse_last;
  logic                         recover_last;
  logic                         unprogrammable;
  logic                         matched;
  logic                         limit_reached;

  assign settle_last  = cycle_count == COUNT_WIDTH'(SETTLE_CYCLES - 1);
  assign setup_last   = cycle_count == COUNT_WIDTH'(SETUP_CYCLES - 1);
  assign pulse_last   = cycle_count == COUNT_WIDTH'(PULSE_CYCLES - 1);
  assign recover_last = cycle_count == COUNT_WIDTH'(RECOVER_CYCLES - 1);

  // A readback 1 where the target wants 0 is a blown fuse that can never be undone.
  assign missing        = target_reg & ~data_line_in;
  assign unprogrammable = |(data_line_in & ~target_reg);
  assign matched        = data_line_in == target_reg;
  assign limit_reached  = pulse_count == PULSE_COUNT_WIDTH'(MAX_PULSES);
  assign address_line   = address_reg;

  always_comb begin
    lowest_index = '0;
    for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
      if (missing[i]) lowest_index = INDEX_WIDTH'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      cycle_count <= '0;
    end else begin
      state <= state_next;
      if (state_next != state || state == IDLE) cycle_count <= '0;
      else cycle_count <= cycle_count + COUNT_WIDTH'(1);
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start) state_next = VERIFY;
      VERIFY:  if (settle_last) begin
                 if (unprogrammable || matched || limit_reached) state_next = DONE;
                 else state_next = SETUP;
               end
      SETUP:   if (setup_last) state_next = PULSE;
      PULSE:   if (pulse_last) state_next = RECOVER;
      RECOVER: if (recover_last) state_next = VERIFY;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      address_reg <= '0;
      target_reg  <= '0;
      pulse_count <= '0;
      bit_select  <= '0;
      error_code  <= 2'b00;
      read_data   <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          address_reg <= write_address;
          target_reg  <= write_data;
          pulse_count <= '0;
          error_code  <= 2'b00;
        end
        VERIFY: if (settle_last) begin
          read_data <= data_line_in;
          if (unprogrammable) error_code <= 2'b01;
          else if (matched) error_code <= 2'b00;
          else if (limit_reached) error_code <= 2'b10;
          else bit_select <= lowest_index;
        end
        SETUP: if (setup_last) pulse_count <= pulse_count + PULSE_COUNT_WIDTH'(1);
        default: ;
      endcase
    end
  end

  always_comb begin
    operation      = 4'b1111;
    vpp_enable     = 1'b0;
    program_strobe = '0;
    busy           = 1'b1;
    done           = 1'b0;
    unique case (state)
      IDLE:    busy = 1'b0;
      VERIFY:  operation = 4'b0000;
      SETUP:   begin
                 operation  = 4'b1110;
                 vpp_enable = 1'b1;
               end
      PULSE:   begin
                 operation      = 4'b1110;
                 vpp_enable     = 1'b1;
                 program_strobe = DATA_WIDTH'(1) << bit_select;
               end
      RECOVER: operation = 4'b1110;
      DONE:    done = 1'b1;
      default: busy = 1'b0;
    endcase
  end

endmodule
